// File: rtl/mips_multicycle.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT sharing one
// request/ready memory port for both instruction fetch and load/store.
module mips_multicycle #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              halt,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir, a_q, b_q, imm_q, alu_q, mdr_q, wait_q;
  logic              run_q;
  logic [31:0]       regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] imm_sext, alu_b, alu_res, wb_data, br_off, pc_ext, j_full;
  logic        is_sw, legal, br_taken, timeout_hit;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign is_sw    = (opcode == OP_SW);
  assign dest     = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data  = (opcode == OP_LW) ? mdr_q : alu_q;
  assign br_off   = {imm_q[29:0], 2'b00};
  assign pc_ext   = 32'(pc);
  assign j_full   = (pc_ext & 32'hF000_0000) | {4'h0, ir[25:0], 2'b00};
  assign br_taken = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
  // wait_q counts cycles already spent waiting; this is the last allowed one
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == TIMEOUT - 1);

  assign halt   = (state == HALT);
  assign pc_out = pc;

  // Opcode/funct legality check used in DECODE
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  // ALU: R-type ops on rs/rt, everything else adds rs + sign-extended imm
  always_comb begin
    alu_b   = (opcode == OP_RTYPE) ? b_q : imm_q;
    alu_res = a_q + alu_b;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_res = a_q - alu_b;
        FN_AND:  alu_res = a_q & alu_b;
        FN_OR:   alu_res = a_q | alu_b;
        FN_SLT:  alu_res = {31'h0, $signed(a_q) < $signed(alu_b)};
        default: alu_res = a_q + alu_b;
      endcase
    end
  end

  // Next state and memory-port/retire outputs, decoded from the current state.
  // Fetch requests are gated by run_q so the port stays idle during reset and
  // for the first cycle after release.
  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        if (run_q) begin
          mem_req  = 1'b1;
          mem_addr = pc;
          if (mem_ready)        state_n = DECODE;
          else if (timeout_hit) state_n = HALT;
        end
      end
      DECODE: state_n = legal ? EXEC : HALT;
      EXEC: begin
        case (opcode)
          OP_LW, OP_SW: state_n = (alu_res[1:0] != 2'b00) ? HALT : MEM;
          OP_BEQ, OP_BNE, OP_J: begin
            state_n = FETCH;
            retire  = 1'b1;
          end
          default: state_n = WB;
        endcase
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        mem_addr  = alu_q[ADDR_W-1:0];
        mem_wdata = is_sw ? b_q : '0;
        if (mem_ready) begin
          state_n = is_sw ? FETCH : WB;
          retire  = is_sw;
        end else if (timeout_hit) begin
          state_n = HALT;
        end
      end
      WB: begin
        state_n = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_n = HALT;
      default: state_n = HALT;
    endcase
  end

  // State register, run enable and memory wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FETCH;
      run_q  <= 1'b0;
      wait_q <= '0;
    end else begin
      state  <= state_n;
      run_q  <= 1'b1;
      wait_q <= (mem_req && !mem_ready) ? wait_q + 32'd1 : '0;
    end
  end

  // Datapath registers: PC, IR, operand latches, ALU result, load data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC[ADDR_W-1:0];
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_req && mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(4);
          end
        end
        DECODE: begin
          a_q   <= regs[rs];
          b_q   <= regs[rt];
          imm_q <= imm_sext;
        end
        EXEC: begin
          alu_q <= alu_res;
          if (opcode == OP_J)
            pc <= j_full[ADDR_W-1:0];
          else if ((opcode == OP_BEQ || opcode == OP_BNE) && br_taken)
            pc <= pc + br_off[ADDR_W-1:0];
        end
        MEM: begin
          if (mem_ready && !is_sw) mdr_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Register file; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (state == WB && dest != 5'd0) begin
      regs[dest] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: memory model with programmable latency, store
// scoreboard, fetch/retire trace and handshake stability monitor.
module tb_mips_multicycle;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready, retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic [31:0] mem  [1024];
  logic [31:0] prog [1024];
  int          wcnt  = 0;
  int          lat   = 0;
  logic        stall = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  typedef struct { logic [31:0] addr; int cyc; } fr_t;
  typedef struct { int fn; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;

  st_t  sb_q[$];
  fr_t  fetch_q[$];
  int   retire_q[$];
  int   cyc = 0;
  int   first_req = -1;
  logic hold_v = 1'b0, hold_we = 1'b0;
  logic [31:0] hold_addr = '0, hold_wdata = '0;

  always #5 clk = ~clk;

  mips_multicycle #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .halt(halt), .pc_out(pc_out)
  );

  assign mem_ready = mem_req && !stall && (wcnt >= lat);
  assign mem_rdata = mem[mem_addr[11:2]];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic logic [31:0] r_op(int rs, int rt, int rd, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(int target);
    return {6'h02, 26'(target >> 2)};
  endfunction

  // Memory model: image reloaded while in reset, latency counter, store write
  always @(posedge clk) begin
    if (!rst) mem <= prog;
    else if (mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Monitor sampled on the falling edge: traces, scoreboard, stability
  always @(negedge clk) begin
    if (!rst) begin
      cyc       <= 0;
      first_req <= -1;
      hold_v    <= 1'b0;
      retire_q.delete();
      fetch_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (mem_req && first_req < 0) first_req <= cyc;
      if (retire) retire_q.push_back(cyc);
      if (mem_req && !mem_we && mem_ready) fetch_q.push_back('{mem_addr, cyc});
      if (mem_req && mem_we && mem_ready) begin
        if (sb_q.size() == 0) begin
          check("store_expected", 32'(sb_q.size()), 32'd1);
        end else begin
          check("store_addr", mem_addr, sb_q[0].addr);
          check("store_data", mem_wdata, sb_q[0].data);
          void'(sb_q.pop_front());
        end
      end
      if (hold_v && !halt) begin
        check("hold_req", 32'(mem_req), 32'd1);
        check("hold_addr", mem_addr, hold_addr);
        check("hold_we", 32'(mem_we), 32'(hold_we));
        check("hold_wdata", mem_wdata, hold_wdata);
      end
      hold_v     <= mem_req && !mem_ready;
      hold_addr  <= mem_addr;
      hold_we    <= mem_we;
      hold_wdata <= mem_wdata;
    end
  end

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = '0;
  endtask

  task automatic put(int addr, logic [31:0] w);
    prog[addr / 4] = w;
  endtask

  task automatic do_reset(int latency, logic stall_v);
    @(negedge clk);
    #2 rst = 1'b0;
    lat   = latency;
    stall = stall_v;
    #1;
    check("reset_ctrl", {28'h0, mem_req, mem_we, retire, halt}, 32'h0);
    check("reset_bus", mem_addr | mem_wdata, 32'h0);
    check("reset_pc", pc_out, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("req_at_release", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1;
    check("first_fetch_req", 32'(mem_req), 32'd1);
    check("first_fetch_addr", mem_addr, 32'h0);
  endtask

  task automatic run_until_halt(string name, int max_cyc);
    int n = 0;
    while (!halt && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_halted"}, 32'(halt), 32'd1);
  endtask

  initial begin
    vec_t vecs[$];
    int   got, bad;
    logic [31:0] exp_f [6];

    vecs.push_back('{'h20, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000});
    vecs.push_back('{'h20, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{'h22, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF});
    vecs.push_back('{'h22, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF});
    vecs.push_back('{'h24, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030});
    vecs.push_back('{'h25, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0});
    vecs.push_back('{'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
    vecs.push_back('{'h2A, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001});
    vecs.push_back('{'h2A, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000});

    // Arithmetic sequence, cycle count, $0 write discard
    clear_prog();
    put('h00, i_op('h08, 0, 1, 5));
    put('h04, i_op('h08, 0, 2, -3));
    put('h08, r_op(1, 2, 3, 'h20));
    put('h0C, i_op('h08, 0, 0, 7));
    put('h10, r_op(0, 0, 5, 'h20));
    put('h14, i_op('h2B, 0, 3, 'h100));
    put('h18, i_op('h2B, 0, 5, 'h104));
    put('h1C, HALT_W);
    sb_q.push_back('{32'h100, 32'd2});
    sb_q.push_back('{32'h104, 32'd0});
    do_reset(0, 1'b0);
    run_until_halt("seq", 200);
    got = (retire_q.size() >= 3) ? retire_q[2] - first_req + 1 : -1;
    check("three_instr_cycles", 32'(got), 32'd12);
    check("seq_retires", 32'(retire_q.size()), 32'd7);
    check("seq_sb_drained", 32'(sb_q.size()), 32'd0);

    // ALU vector table through lw/op/sw, one wait cycle per access
    clear_prog();
    foreach (vecs[i]) begin
      put('h200 + 8 * i, vecs[i].a);
      put('h204 + 8 * i, vecs[i].b);
      put(16 * i + 'h0, i_op('h23, 0, 1, 'h200 + 8 * i));
      put(16 * i + 'h4, i_op('h23, 0, 2, 'h204 + 8 * i));
      put(16 * i + 'h8, r_op(1, 2, 3, vecs[i].fn));
      put(16 * i + 'hC, i_op('h2B, 0, 3, 'h300 + 4 * i));
      sb_q.push_back('{32'h300 + 32'(4 * i), vecs[i].exp});
    end
    put(16 * vecs.size(), HALT_W);
    do_reset(1, 1'b0);
    run_until_halt("alu", 3000);
    check("alu_sb_drained", 32'(sb_q.size()), 32'd0);

    // Store then load with three wait cycles each, behind a jump
    clear_prog();
    put('h00, j_op('h40));
    put('h40, i_op('h08, 0, 1, 5));
    put('h44, i_op('h2B, 0, 1, 8));
    put('h48, i_op('h23, 0, 4, 8));
    put('h4C, i_op('h2B, 0, 4, 'h10));
    put('h50, HALT_W);
    sb_q.push_back('{32'h8, 32'd5});
    sb_q.push_back('{32'h10, 32'd5});
    do_reset(3, 1'b0);
    run_until_halt("ldst", 500);
    check("ldst_retires", 32'(retire_q.size()), 32'd5);
    check("ldst_sb_drained", 32'(sb_q.size()), 32'd0);

    // beq $0,$0,-1 at 0x10 spins, refetching every 3 cycles
    clear_prog();
    put('h00, j_op('h10));
    put('h10, i_op('h04, 0, 0, -1));
    do_reset(0, 1'b0);
    repeat (30) @(negedge clk);
    #1;
    check("spin_fetches", 32'(fetch_q.size() >= 6), 32'd1);
    if (fetch_q.size() >= 6) begin
      for (int i = 1; i < 6; i++) begin
        check("spin_addr", fetch_q[i].addr, 32'h10);
        check("spin_gap", 32'(fetch_q[i].cyc - fetch_q[i-1].cyc), 32'd3);
      end
    end

    // bne not taken, then bne taken forward
    clear_prog();
    put('h00, j_op('h10));
    put('h10, i_op('h05, 0, 0, 4));
    put('h14, i_op('h08, 0, 1, 1));
    put('h18, i_op('h05, 1, 0, 2));
    put('h1C, HALT_W);
    put('h20, HALT_W);
    put('h24, i_op('h2B, 0, 1, 'h100));
    put('h28, HALT_W);
    sb_q.push_back('{32'h100, 32'd1});
    exp_f = '{32'h0, 32'h10, 32'h14, 32'h18, 32'h24, 32'h28};
    do_reset(0, 1'b0);
    run_until_halt("bne", 200);
    check("bne_fetch_count", 32'(fetch_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < fetch_q.size()) check("bne_fetch_addr", fetch_q[i].addr, exp_f[i]);
    check("bne_sb_drained", 32'(sb_q.size()), 32'd0);

    // Illegal opcode 0x3F: absorbing halt
    clear_prog();
    put('h00, HALT_W);
    do_reset(0, 1'b0);
    run_until_halt("illop", 20);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (mem_req || !halt || retire) bad++;
    end
    check("halt_absorbing", 32'(bad), 32'd0);
    check("illop_retires", 32'(retire_q.size()), 32'd0);

    // Illegal funct halts
    clear_prog();
    put('h00, r_op(0, 0, 1, 'h21));
    do_reset(0, 1'b0);
    run_until_halt("illfn", 20);
    check("illfn_fetches", 32'(fetch_q.size()), 32'd1);

    // Misaligned lw from 0x6 halts before any memory access
    clear_prog();
    put('h00, i_op('h08, 0, 1, 6));
    put('h04, i_op('h23, 1, 2, 0));
    put('h08, i_op('h2B, 0, 1, 'h100));
    do_reset(0, 1'b0);
    run_until_halt("misal", 50);
    repeat (5) @(negedge clk);
    #1;
    check("misal_fetches", 32'(fetch_q.size()), 32'd1 + 32'd1);
    check("misal_retires", 32'(retire_q.size()), 32'd1);
    check("misal_req_low", 32'(mem_req), 32'd0);

    // Fetch timeout: four unanswered cycles then halt; reset recovers
    clear_prog();
    put('h00, HALT_W);
    do_reset(0, 1'b1);
    got = 1;
    for (int i = 0; i < 20 && !halt; i++) begin
      @(negedge clk);
      #1;
      if (!halt && mem_req) got++;
    end
    check("timeout_halt", 32'(halt), 32'd1);
    check("timeout_req_cycles", 32'(got), 32'd4);
    do_reset(0, 1'b0);
    run_until_halt("after_timeout", 20);
    check("after_timeout_fetch", 32'(fetch_q.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
